// File: rtl/fetch_unit_pkg.sv
// Shared defaults for the instruction-fetch slice; the instruction-memory model
// uses the same values, so the program length agrees on both sides.
package fetch_unit_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_INSTR_W   = 32;
  localparam int DEF_NUM_INSTR = 11;
  localparam int DEF_DEPTH     = 2;
  localparam int DEF_RESET_PC  = 0;

endpackage

// File: rtl/fetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} with flush; the head is read
// straight out of storage, so it is valid whenever the FIFO is not empty.
module fetch_unit_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the combinational-read
// instruction memory and feeds decode from a small prefetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                INSTR_W   = DEF_INSTR_W,
  parameter int                NUM_INSTR = DEF_NUM_INSTR,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_instr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_done
);

  localparam int                CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(NUM_INSTR);

  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic                      done_q, done_d;
  logic                      at_end;
  logic                      accept;
  logic                      push, pop;
  logic                      next_empty;
  logic                      fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [ADDR_W+INSTR_W-1:0] head;

  // Handshake: decode takes the head on any cycle where o_valid && i_ready are
  // both high; o_valid never depends on i_ready, and the head is stable until taken.
  assign at_end = (pc_q >= END_PC);
  assign accept = o_valid && i_ready;
  assign pop    = accept && !i_redirect;
  assign push   = !i_redirect && !at_end && (!fifo_full || accept);

  always_comb begin
    pc_d = pc_q;
    if (i_redirect)  pc_d = i_redirect_pc;
    else if (push)   pc_d = pc_q + 1'b1;

    // Occupancy after this edge, so o_done rises in the same cycle the queue empties.
    next_empty = 1'b0;
    if (i_redirect)                                    next_empty = 1'b1;
    else if (fifo_empty && !push)                      next_empty = 1'b1;
    else if ((fifo_count == CNT_W'(1)) && pop && !push) next_empty = 1'b1;

    done_d = (pc_d >= END_PC) && next_empty;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q   <= RESET_PC;
      done_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      done_q <= done_d;
    end
  end

  fetch_unit_fifo #(
    .W     (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .i_data  ({pc_q, i_imem_instr}),
    .o_head  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_imem_addr = pc_q;
  assign o_valid     = !fifo_empty;
  assign o_pc        = head[ADDR_W+INSTR_W-1 -: ADDR_W];
  assign o_instr     = head[INSTR_W-1:0];
  assign o_done      = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver queues the PCs decode should see
// from each reset/redirect onwards, and a negedge monitor checks every handshake.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int IW = DEF_INSTR_W;
  localparam int NI = DEF_NUM_INSTR;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          valid;
  logic          ready = 1'b0;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          done;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;
  int            vec_cnt  = 0;
  int            miss_cnt = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000 + k
  assign imem_instr = IW'(32'h1000) + IW'(imem_addr);

  fetch_unit dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_addr   (imem_addr),
    .i_imem_instr  (imem_instr),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_done        (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head must be the next PC decode is owed.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_head: got pc 0x%0h, expected no instruction (t=%0t)", pc, $time);
      end else begin
        exp_pc = exp_q.pop_front();
        check("head_pc", 64'(pc), 64'(exp_pc));
        check("head_instr", 64'(instr), 64'(32'h1000 + exp_pc));
      end
    end
  end

  task automatic load_exp(input logic [AW-1:0] start);
    exp_q.delete();
    for (int p = int'(start); p < NI; p++) exp_q.push_back(AW'(p));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    ready    = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    load_exp('0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [AW-1:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    cyc();
    redirect = 1'b0;
    load_exp(target);
    check("redir_valid", 64'(valid), 64'd0);
    check("redir_addr", 64'(imem_addr), 64'(target));
    check("redir_done", 64'(done), 64'(target >= AW'(NI)));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready = 1'b1;
    while (!done && n < 100) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Full program with decode always ready: one instruction per cycle.
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      cyc();
      check("t1_valid", 64'(valid), 64'd1);
      check("t1_pc", 64'(pc), 64'(k));
      check("t1_not_done", 64'(done), 64'd0);
    end
    cyc();
    check("t1_done", 64'(done), 64'd1);
    check("t1_valid_end", 64'(valid), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure fills the queue; release delivers back to back.
    do_reset();
    for (int k = 0; k < 5; k++) cyc();
    check("t2_addr_hold", 64'(imem_addr), 64'd2);
    check("t2_head_hold", 64'(pc), 64'd0);
    check("t2_valid_hold", 64'(valid), 64'd1);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t2_flow_valid", 64'(valid), 64'd1);
      check("t2_flow_pc", 64'(pc), 64'(k));
      cyc();
    end
    drain("t2");

    // Redirect while the queue holds pcs 3 and 4.
    do_reset();
    ready = 1'b1;
    repeat (4) cyc();
    check("t3_head", 64'(pc), 64'd3);
    ready = 1'b0;
    cyc();
    check("t3_full_head", 64'(pc), 64'd3);
    check("t3_full_addr", 64'(imem_addr), 64'd5);
    do_redirect(AW'(7));
    cyc();
    check("t3_target_valid", 64'(valid), 64'd1);
    check("t3_target_pc", 64'(pc), 64'd7);
    check("t3_target_instr", 64'(instr), 64'h1007);
    drain("t3");

    // Redirect past the end of the program, then restart.
    do_redirect(AW'(20));
    repeat (3) begin
      cyc();
      check("t4_idle_valid", 64'(valid), 64'd0);
      check("t4_idle_done", 64'(done), 64'd1);
    end
    do_redirect('0);
    cyc();
    check("t4_restart_valid", 64'(valid), 64'd1);
    check("t4_restart_pc", 64'(pc), 64'd0);
    drain("t4");

    // Redirect together with a handshake, then asynchronous resets.
    do_reset();
    ready = 1'b1;
    repeat (3) cyc();
    check("t5_valid", 64'(valid), 64'd1);
    do_redirect(AW'(5));
    cyc();
    cyc();
    check("t5_stream_valid", 64'(valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_async_valid", 64'(valid), 64'd0);
    check("t5_async_addr", 64'(imem_addr), 64'd0);
    check("t5_async_done", 64'(done), 64'd0);
    load_exp('0);
    cyc();
    rst = 1'b0;
    do_redirect(AW'(15));
    cyc();
    #1 rst = 1'b1;
    #1;
    check("t5_async_done_clr", 64'(done), 64'd0);
    check("t5_async_addr2", 64'(imem_addr), 64'd0);
    load_exp('0);
    cyc();
    rst = 1'b0;
    drain("t5");

    // Randomized ready and redirects.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 19) == 0) do_redirect(AW'($urandom_range(0, 15)));
        else cyc();
        if (done) check("rnd_done_drained", 64'(exp_q.size()), 64'd0);
      end
      drain("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
